// File: rtl/wb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter slice.
package wb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int unsigned PORT_IF  = 0;
    localparam int unsigned PORT_LSU = 1;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: flags the TIMEOUT-th consecutive enabled cycle since clear.
module wb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    if (TIMEOUT == 0) begin : g_off
        logic unused_wd;
        assign unused_wd = ^{clk_i, rst_i, clear_i, enable_i};
        assign expired_o = 1'b0;
    end else begin : g_on
        localparam int unsigned CW = $clog2(TIMEOUT + 1);
        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clear_i) begin
                cnt_d = '0;
            end else if (enable_i && cnt_q != CW'(TIMEOUT)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end

        // cnt_q holds completed cycles, so the current one is the TIMEOUT-th.
        assign expired_o = enable_i && !clear_i && (cnt_q == CW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Round-robin arbiter sharing one Wishbone B4 classic master port between
// instruction fetch (port 0) and load/store (port 1), with a bus watchdog.
module wb_arbiter_2m
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned AW      = WB_AW,
    parameter int unsigned DW      = WB_DW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            r0_req_i,
    input  logic            r0_we_i,
    input  logic [AW-1:0]   r0_addr_i,
    input  logic [DW-1:0]   r0_dat_i,
    input  logic [DW/8-1:0] r0_sel_i,
    output logic [DW-1:0]   r0_dat_o,
    output logic            r0_ack_o,
    output logic            r0_err_o,
    input  logic            r1_req_i,
    input  logic            r1_we_i,
    input  logic [AW-1:0]   r1_addr_i,
    input  logic [DW-1:0]   r1_dat_i,
    input  logic [DW/8-1:0] r1_sel_i,
    output logic [DW-1:0]   r1_dat_o,
    output logic            r1_ack_o,
    output logic            r1_err_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [AW-1:0]   wbm_addr_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o
    ,output logic [1:0]     gnt_o
);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdat_q, wdat_d;
    logic [DW/8-1:0]   sel_q, sel_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        err_q, err_d;
    logic [DW-1:0]     rdat0_q, rdat0_d, rdat1_q, rdat1_d;
    logic              elig0, elig1, win, grant, wd_expired;

    // A port is masked while its own completion pulse is visible.
    assign elig0 = r0_req_i && !(ack_q[PORT_IF]  || err_q[PORT_IF]);
    assign elig1 = r1_req_i && !(ack_q[PORT_LSU] || err_q[PORT_LSU]);
    assign win   = (elig0 && elig1) ? ~last_q : elig1;
    assign grant = (state_q == IDLE) && (elig0 || elig1);

    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (grant),
        .enable_i  (state_q == BUSY),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        ack_d   = '0;
        err_d   = '0;
        rdat0_d = rdat0_q;
        rdat1_d = rdat1_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d = win;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    cyc_d   = 1'b1;
                    we_d    = win ? r1_we_i   : r0_we_i;
                    addr_d  = win ? r1_addr_i : r0_addr_i;
                    wdat_d  = win ? r1_dat_i  : r0_dat_i;
                    sel_d   = win ? r1_sel_i  : r0_sel_i;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (wbm_err_i || wbm_ack_i || wd_expired) begin
                    if (wbm_err_i || wd_expired) begin
                        err_d[owner_q] = 1'b1;
                    end else begin
                        ack_d[owner_q] = 1'b1;
                        if (owner_q) rdat1_d = wbm_dat_i;
                        else         rdat0_d = wbm_dat_i;
                    end
                    cyc_d   = 1'b0;
                    gnt_d   = 2'b00;
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rdat0_q <= '0;
            rdat1_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat0_q <= rdat0_d;
            rdat1_q <= rdat1_d;
        end
    end

    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_we_o   = we_q;
    assign wbm_addr_o = addr_q;
    assign wbm_dat_o  = wdat_q;
    assign wbm_sel_o  = sel_q;
    assign gnt_o      = gnt_q;
    assign r0_ack_o   = ack_q[PORT_IF];
    assign r0_err_o   = err_q[PORT_IF];
    assign r0_dat_o   = rdat0_q;
    assign r1_ack_o   = ack_q[PORT_LSU];
    assign r1_err_o   = err_q[PORT_LSU];
    assign r1_dat_o   = rdat1_q;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m (watchdog TIMEOUT=4).
module tb_wb_arbiter_2m;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        r0_req_i, r0_we_i, r1_req_i, r1_we_i;
    logic [31:0] r0_addr_i, r0_dat_i, r1_addr_i, r1_dat_i;
    logic [3:0]  r0_sel_i, r1_sel_i;
    logic [31:0] r0_dat_o, r1_dat_o;
    logic        r0_ack_o, r0_err_o, r1_ack_o, r1_err_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_addr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [1:0]  gnt_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    wb_arbiter_2m #(.TIMEOUT(4), .AW(32), .DW(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .r0_req_i(r0_req_i), .r0_we_i(r0_we_i), .r0_addr_i(r0_addr_i),
        .r0_dat_i(r0_dat_i), .r0_sel_i(r0_sel_i), .r0_dat_o(r0_dat_o),
        .r0_ack_o(r0_ack_o), .r0_err_o(r0_err_o),
        .r1_req_i(r1_req_i), .r1_we_i(r1_we_i), .r1_addr_i(r1_addr_i),
        .r1_dat_i(r1_dat_i), .r1_sel_i(r1_sel_i), .r1_dat_o(r1_dat_o),
        .r1_ack_o(r1_ack_o), .r1_err_o(r1_err_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .gnt_o(gnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        r0_req_i = 0; r0_we_i = 0; r0_addr_i = '0; r0_dat_i = '0; r0_sel_i = '0;
        r1_req_i = 0; r1_we_i = 0; r1_addr_i = '0; r1_dat_i = '0; r1_sel_i = '0;
        wbm_dat_i = '0; wbm_ack_i = 0; wbm_err_i = 0;
        tick(); tick();
        rst_i = 1'b0;

        check("rst_cyc",  {31'b0, wbm_cyc_o}, 32'd0);
        check("rst_stb",  {31'b0, wbm_stb_o}, 32'd0);
        check("rst_we",   {31'b0, wbm_we_o},  32'd0);
        check("rst_addr", wbm_addr_o, 32'd0);
        check("rst_sel",  {28'b0, wbm_sel_o}, 32'd0);
        check("rst_gnt",  {30'b0, gnt_o}, 32'd0);
        check("rst_pulses", {28'b0, r0_ack_o, r0_err_o, r1_ack_o, r1_err_o}, 32'd0);
        check("rst_r0dat", r0_dat_o, 32'd0);

        // Single read: ack two cycles after stb.
        r0_req_i = 1; r0_we_i = 0; r0_addr_i = 32'h100; r0_sel_i = 4'hF;
        tick();
        check("rd_cyc",  {31'b0, wbm_cyc_o}, 32'd1);
        check("rd_stb",  {31'b0, wbm_stb_o}, 32'd1);
        check("rd_addr", wbm_addr_o, 32'h100);
        check("rd_gnt",  {30'b0, gnt_o}, 32'd1);
        tick();
        check("rd_hold", {31'b0, wbm_cyc_o}, 32'd1);
        check("rd_noack", {31'b0, r0_ack_o}, 32'd0);
        wbm_ack_i = 1; wbm_dat_i = 32'hDEADBEEF;
        tick();
        wbm_ack_i = 0; wbm_dat_i = '0;
        check("rd_ack",  {31'b0, r0_ack_o}, 32'd1);
        check("rd_dat",  r0_dat_o, 32'hDEADBEEF);
        check("rd_cyclo", {31'b0, wbm_cyc_o}, 32'd0);
        check("rd_gntlo", {30'b0, gnt_o}, 32'd0);
        r0_req_i = 0;
        tick();
        check("rd_ackpulse", {31'b0, r0_ack_o}, 32'd0);

        // Masking: r0 keeps req through its ack pulse.
        r0_req_i = 1; r0_addr_i = 32'h104;
        tick();
        check("mk_cyc", {31'b0, wbm_cyc_o}, 32'd1);
        wbm_ack_i = 1; wbm_dat_i = 32'h11112222;
        tick();
        wbm_ack_i = 0;
        check("mk_ack", {31'b0, r0_ack_o}, 32'd1);
        tick();
        check("mk_noreissue", {31'b0, wbm_cyc_o}, 32'd0);
        check("mk_gnt", {30'b0, gnt_o}, 32'd0);
        r0_req_i = 0;
        tick();
        check("mk_idle", {31'b0, wbm_cyc_o}, 32'd0);

        // Contention from reset: grants alternate 0,1,0,1.
        rst_i = 1; tick(); rst_i = 0;
        r0_req_i = 1; r0_we_i = 0; r0_addr_i = 32'h10;
        r1_req_i = 1; r1_we_i = 0; r1_addr_i = 32'h20; r1_sel_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ct_gnt",  {30'b0, gnt_o}, (i % 2 == 0) ? 32'd1 : 32'd2);
            check("ct_addr", wbm_addr_o, (i % 2 == 0) ? 32'h10 : 32'h20);
            wbm_ack_i = 1; wbm_dat_i = 32'hA000_0000 + 32'(i);
            tick();
            wbm_ack_i = 0;
            check("ct_cyclo", {31'b0, wbm_cyc_o}, 32'd0);
            check("ct_acks", {30'b0, r1_ack_o, r0_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd2);
            check("ct_dat", (i % 2 == 0) ? r0_dat_o : r1_dat_o, 32'hA000_0000 + 32'(i));
        end
        r0_req_i = 0; r1_req_i = 0;
        tick();
        check("ct_end", {31'b0, wbm_cyc_o}, 32'd0);

        // Bus error on r1 write; then ack+err together.
        r1_req_i = 1; r1_we_i = 1; r1_addr_i = 32'h200; r1_sel_i = 4'b0011; r1_dat_i = 32'hCAFE0000;
        tick();
        check("be_sel",  {28'b0, wbm_sel_o}, 32'h3);
        check("be_we",   {31'b0, wbm_we_o}, 32'd1);
        check("be_wdat", wbm_dat_o, 32'hCAFE0000);
        check("be_gnt",  {30'b0, gnt_o}, 32'd2);
        wbm_err_i = 1; wbm_dat_i = 32'h55555555;
        tick();
        wbm_err_i = 0;
        check("be_err",  {31'b0, r1_err_o}, 32'd1);
        check("be_noack", {31'b0, r1_ack_o}, 32'd0);
        check("be_dat",  r1_dat_o, 32'hA0000003);
        r1_req_i = 0;
        tick();
        check("be_errpulse", {31'b0, r1_err_o}, 32'd0);
        r1_req_i = 1;
        tick();
        wbm_ack_i = 1; wbm_err_i = 1;
        tick();
        wbm_ack_i = 0; wbm_err_i = 0;
        check("ae_err",  {31'b0, r1_err_o}, 32'd1);
        check("ae_noack", {31'b0, r1_ack_o}, 32'd0);
        r1_req_i = 0;
        tick();

        // Watchdog timeout on r0, then r1 served normally.
        r0_req_i = 1; r0_we_i = 0; r0_addr_i = 32'h300;
        tick();
        check("to_cyc", {31'b0, wbm_cyc_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_wait", {30'b0, wbm_cyc_o, r0_err_o}, 32'd2);
        end
        tick();
        check("to_err",   {31'b0, r0_err_o}, 32'd1);
        check("to_noack", {31'b0, r0_ack_o}, 32'd0);
        check("to_cyclo", {31'b0, wbm_cyc_o}, 32'd0);
        r0_req_i = 0;
        r1_req_i = 1; r1_we_i = 0; r1_addr_i = 32'h400;
        tick();
        check("to_r1gnt", {30'b0, gnt_o}, 32'd2);
        check("to_r1addr", wbm_addr_o, 32'h400);
        wbm_ack_i = 1; wbm_dat_i = 32'h0BADF00D;
        tick();
        wbm_ack_i = 0;
        check("to_r1ack", {31'b0, r1_ack_o}, 32'd1);
        r1_req_i = 0;
        tick();

        // Make port 0 the last served, then reset during an r1 transfer.
        r0_req_i = 1; r0_addr_i = 32'h480;
        tick();
        wbm_ack_i = 1;
        tick();
        wbm_ack_i = 0;
        r0_req_i = 0;
        tick();
        r1_req_i = 1; r1_addr_i = 32'h500;
        tick();
        check("rm_gnt", {30'b0, gnt_o}, 32'd2);
        rst_i = 1;
        tick();
        rst_i = 0;
        check("rm_cyc",  {30'b0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        check("rm_gnt0", {30'b0, gnt_o}, 32'd0);
        check("rm_addr", wbm_addr_o, 32'd0);
        check("rm_pulses", {28'b0, r0_ack_o, r0_err_o, r1_ack_o, r1_err_o}, 32'd0);
        check("rm_r1dat", r1_dat_o, 32'd0);
        r0_req_i = 1; r0_addr_i = 32'h600;
        tick();
        check("rm_p0first", {30'b0, gnt_o}, 32'd1);
        check("rm_p0addr", wbm_addr_o, 32'h600);
        check("rm_nopulse", {28'b0, r0_ack_o, r0_err_o, r1_ack_o, r1_err_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Shares the core's single Wishbone B4 classic master port between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Grants the bus round-robin, one single-beat classic transfer per grant.
- Routes ack/err/read data back to the owner.
- A bus watchdog terminates hung transfers with an error.

Parameters:
- TIMEOUT, 255, cycles in BUSY without wbm_ack_i/wbm_err_i before forced error termination; 0 disables the watchdog.
- AW, 32, address width.
- DW, 32, data width (sel width = DW/8).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- r0_req_i  in  1  port 0 request, level, held until r0_ack_o/r0_err_o
- r0_we_i  in  1  port 0 write enable
- r0_addr_i  in  AW  port 0 address
- r0_dat_i  in  DW  port 0 write data
- r0_sel_i  in  DW/8  port 0 byte select
- r0_dat_o  out  DW  port 0 read data, valid while r0_ack_o=1
- r0_ack_o  out  1  port 0 completion pulse
- r0_err_o  out  1  port 0 error pulse (bus error or timeout)
- r1_*  same set for port 1
- wbm_dat_i  in  DW  bus read data
- wbm_ack_i  in  1  bus ack
- wbm_err_i  in  1  bus error
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  bus strobe
- wbm_we_o  out  1  bus write enable
- wbm_addr_o  out  AW  bus address
- wbm_dat_o  out  DW  bus write data
- wbm_sel_o  out  DW/8  bus byte select
- gnt_o  out  2  one-hot current owner, 00 when idle

Behaviour:
- Interface decision: one clock clk_i; rst_i is synchronous, active-high.
- Reset values:
  - wbm_cyc_o, wbm_stb_o, wbm_we_o = 0.
  - wbm_addr_o, wbm_dat_o, wbm_sel_o = 0.
  - rX_ack_o, rX_err_o = 0; rX_dat_o = 0.
  - gnt_o = 00; state = IDLE; round-robin pointer favours port 0; watchdog count = 0.
- States: IDLE, BUSY.
- IDLE:
  - Eligible requester: rX_req_i=1 and not masked. A port is masked during the cycle its own ack/err pulse is high, which prevents re-issuing a just-completed request.
  - One eligible port: grant it.
  - Both eligible: grant the port not granted last.
  - On grant edge: register the winner's we/addr/dat/sel onto wbm_*; set cyc=stb=1; set gnt_o; clear the watchdog; go to BUSY.
  - Latency: request sampled at edge N gives cyc/stb=1 after edge N.
- BUSY:
  - wbm_* outputs are held stable.
  - wbm_ack_i=1 at edge M, after edge M:
    - cyc=stb=0, gnt_o=00.
    - Owner's ack pulses for exactly one cycle.
    - rX_dat_o = wbm_dat_i captured at M (reads and writes alike).
    - Pointer updated; state goes to IDLE.
  - wbm_err_i=1: same as ack, but the owner's err pulses instead of ack; rX_dat_o is unchanged.
  - ack and err both high in the same cycle: err wins, no ack pulse.
  - Watchdog: counts BUSY cycles; when the count reaches TIMEOUT with no ack/err, terminate exactly as for err.
- Requester deasserts req while BUSY: the transfer still completes and the pulse is still emitted. The requester must ignore it.
- Minimum spacing: back-to-back transfers have one IDLE cycle between cyc falling and rising.
- The non-owner's inputs are ignored while BUSY; its request waits.
- Reset mid-transfer: cyc/stb drop after the reset edge; no ack/err pulse is emitted.
- Never more than one rX_ack_o/rX_err_o high in any cycle.
- Watchdog counter width = clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Package wb_pkg:
  - State localparams (IDLE=0, BUSY=1).
  - Port index constants (PORT_IF=0, PORT_LSU=1).
  - Default AW/DW.
- One sub-module: wb_watchdog.
  - Inputs: clear, enable.
  - Output: expired.
  - Parameter: TIMEOUT.
  - Tied low when TIMEOUT=0.

Test Plan:
- Single read: r0 requests read addr 0x100, slave acks 2 cycles after stb with 0xDEADBEEF -> cyc high 1 cycle after req, r0_ack_o one-cycle pulse, r0_dat_o=0xDEADBEEF, cyc low same cycle as ack pulse.
- Contention: r0 and r1 request together from reset, each held until acked -> r0 served first, then r1. With both held continuously, grants alternate 0,1,0,1 with one idle cycle between transfers.
- Bus error: r1 write to 0x200 with sel=4'b0011, slave asserts err -> wbm_sel_o=0011, wbm_we_o=1, r1_err_o pulses once, r1_ack_o stays 0.
- Timeout: TIMEOUT=4, slave never responds -> r0_err_o pulses after 4 BUSY cycles, cyc drops; a subsequent r1 request is granted normally.
- Reset mid-transfer: assert rst_i while BUSY -> all outputs at reset values next cycle, no ack/err pulse; a request after reset is granted to port 0 first.
- Masking: r0 holds req one cycle past its ack pulse -> no second transfer issued for r0 in that cycle.
